// File: rtl/mag_compare_if.sv
// Operand/result bundle for the unsigned magnitude comparator.
// master drives the operands and the valid strobe, slave returns the flags.
interface mag_compare_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic             greater;
    logic             less;
    logic             greater_q;
    logic             less_q;
    logic             equal_q;
    logic             out_valid;

    modport master (
        output a, b, in_valid,
        input  greater, less, greater_q, less_q, equal_q, out_valid
    );

    modport slave (
        input  a, b, in_valid,
        output greater, less, greater_q, less_q, equal_q, out_valid
    );
endinterface

// File: rtl/mag_compare.sv
// Unsigned WIDTH-bit magnitude comparator: a tree of 2-bit compare cells with
// combinational gt/lt flags and a one-cycle registered gt/lt/eq result.
module mag_compare #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    mag_compare_if.slave bus
);
    localparam int NCELL = WIDTH / 2;
    localparam int NLVL  = $clog2(NCELL) + 1;

    logic gt_c;
    logic lt_c;
    logic greater_r;
    logic less_r;
    logic equal_r;
    logic out_valid_r;

    // Level 0 holds one cell per bit pair (index k covers bits 2k+1:2k);
    // each following level merges neighbouring pairs, odd index being the upper half.
    genvar lv, k;
    generate
        for (lv = 0; lv < NLVL; lv++) begin : g_lvl
            localparam int NN = NCELL >> lv;
            logic [NN-1:0] gt;
            logic [NN-1:0] lt;

            if (lv == 0) begin : g_leaf
                for (k = 0; k < NN; k++) begin : g_cell
                    logic [1:0] x;
                    logic [1:0] y;
                    assign x = bus.a[2*k+1 -: 2];
                    assign y = bus.b[2*k+1 -: 2];
                    assign gt[k] = (x[1] & ~y[1]) | (~(x[1] ^ y[1]) & x[0] & ~y[0]);
                    assign lt[k] = (~x[1] & y[1]) | (~(x[1] ^ y[1]) & ~x[0] & y[0]);
                end
            end else begin : g_node
                for (k = 0; k < NN; k++) begin : g_merge
                    logic gt_hi;
                    logic lt_hi;
                    logic gt_lo;
                    logic lt_lo;
                    assign gt_hi = g_lvl[lv-1].gt[2*k+1];
                    assign lt_hi = g_lvl[lv-1].lt[2*k+1];
                    assign gt_lo = g_lvl[lv-1].gt[2*k];
                    assign lt_lo = g_lvl[lv-1].lt[2*k];
                    assign gt[k] = gt_hi | (~gt_hi & ~lt_hi & gt_lo);
                    assign lt[k] = lt_hi | (~gt_hi & ~lt_hi & lt_lo);
                end
            end
        end
    endgenerate

    assign gt_c = g_lvl[NLVL-1].gt[0];
    assign lt_c = g_lvl[NLVL-1].lt[0];

    // Results hold while in_valid is low so the last sample stays readable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            greater_r   <= 1'b0;
            less_r      <= 1'b0;
            equal_r     <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= bus.in_valid;
            if (bus.in_valid) begin
                greater_r <= gt_c;
                less_r    <= lt_c;
                equal_r   <= ~gt_c & ~lt_c;
            end
        end
    end

    assign bus.greater   = gt_c;
    assign bus.less      = lt_c;
    assign bus.greater_q = greater_r;
    assign bus.less_q    = less_r;
    assign bus.equal_q   = equal_r;
    assign bus.out_valid = out_valid_r;
endmodule

// File: tb/tb_mag_compare.sv
// Directed vector table plus exhaustive sweeps for WIDTH 2/4/8 and
// hand-written latency, reset and back-to-back sequences.
module tb_mag_compare;
    logic clk;
    logic rst_n;

    mag_compare_if #(.WIDTH(2)) if2 ();
    mag_compare_if #(.WIDTH(4)) if4 ();
    mag_compare_if #(.WIDTH(8)) if8 ();

    mag_compare #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    mag_compare #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    mag_compare #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       gt;
        logic       lt;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_q(input string name, input logic gq, input logic lq, input logic eq,
                         input logic ov);
        chk({name, ".greater_q"}, {7'd0, if8.greater_q}, {7'd0, gq});
        chk({name, ".less_q"},    {7'd0, if8.less_q},    {7'd0, lq});
        chk({name, ".equal_q"},   {7'd0, if8.equal_q},   {7'd0, eq});
        chk({name, ".out_valid"}, {7'd0, if8.out_valid}, {7'd0, ov});
    endtask

    initial begin
        tbl[0]  = '{8'h00, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{8'hFF, 8'h00, 1'b1, 1'b0};
        tbl[2]  = '{8'h00, 8'hFF, 1'b0, 1'b1};
        tbl[3]  = '{8'h80, 8'h7F, 1'b1, 1'b0};
        tbl[4]  = '{8'hA5, 8'hA5, 1'b0, 1'b0};
        tbl[5]  = '{8'h7F, 8'h80, 1'b0, 1'b1};
        tbl[6]  = '{8'h01, 8'h02, 1'b0, 1'b1};
        tbl[7]  = '{8'h10, 8'h0F, 1'b1, 1'b0};
        tbl[8]  = '{8'hFE, 8'hFF, 1'b0, 1'b1};
        tbl[9]  = '{8'hC3, 8'hC2, 1'b1, 1'b0};
        tbl[10] = '{8'h3C, 8'h3D, 1'b0, 1'b1};
        tbl[11] = '{8'hFF, 8'hFF, 1'b0, 1'b0};

        rst_n = 1'b0;
        if2.a = '0; if2.b = '0; if2.in_valid = 1'b0;
        if4.a = '0; if4.b = '0; if4.in_valid = 1'b0;
        if8.a = '0; if8.b = '0; if8.in_valid = 1'b0;
        #12;
        chk_q("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: combinational flags between edges, registered copy after the edge.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if8.a = tbl[i].a;
            if8.b = tbl[i].b;
            if8.in_valid = 1'b1;
            #1;
            chk($sformatf("tbl%0d.greater", i), {7'd0, if8.greater}, {7'd0, tbl[i].gt});
            chk($sformatf("tbl%0d.less", i),    {7'd0, if8.less},    {7'd0, tbl[i].lt});
            @(posedge clk);
            #1;
            chk_q($sformatf("tbl%0d", i), tbl[i].gt, tbl[i].lt, ~tbl[i].gt & ~tbl[i].lt, 1'b1);
        end

        // Latency and hold.
        @(negedge clk);
        if8.a = 8'd3; if8.b = 8'd9; if8.in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk_q("lat", 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        if8.in_valid = 1'b0; if8.a = 8'd200; if8.b = 8'd1;
        #1;
        chk("hold.greater", {7'd0, if8.greater}, 8'd1);
        @(posedge clk);
        #1;
        chk_q("hold", 1'b0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle while greater_q is set.
        @(negedge clk);
        if8.a = 8'd9; if8.b = 8'd2; if8.in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk_q("pre_rst", 1'b1, 1'b0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_q("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        if8.a = 8'd1; if8.b = 8'd6;
        #1;
        chk("rst.less", {7'd0, if8.less}, 8'd1);
        chk("rst.greater", {7'd0, if8.greater}, 8'd0);
        @(posedge clk);
        #1;
        chk_q("rst_held", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        if8.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk_q("rel_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back captures.
        @(negedge clk);
        if8.a = 8'd4; if8.b = 8'd4; if8.in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk_q("b2b0", 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        if8.a = 8'd9; if8.b = 8'd2;
        @(posedge clk);
        #1;
        chk_q("b2b1", 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        if8.a = 8'd1; if8.b = 8'd6;
        @(posedge clk);
        #1;
        chk_q("b2b2", 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        if8.in_valid = 1'b0;

        // Exhaustive combinational sweeps against the bench's own > / < model.
        for (int i = 0; i < 16; i++) begin
            if2.a = i[3:2]; if2.b = i[1:0];
            #1;
            chk($sformatf("w2 a=%0d b=%0d greater", i[3:2], i[1:0]),
                {7'd0, if2.greater}, {7'd0, i[3:2] > i[1:0]});
            chk($sformatf("w2 a=%0d b=%0d less", i[3:2], i[1:0]),
                {7'd0, if2.less}, {7'd0, i[3:2] < i[1:0]});
        end
        for (int i = 0; i < 256; i++) begin
            if4.a = i[7:4]; if4.b = i[3:0];
            #1;
            chk($sformatf("w4 a=%0d b=%0d greater", i[7:4], i[3:0]),
                {7'd0, if4.greater}, {7'd0, i[7:4] > i[3:0]});
            chk($sformatf("w4 a=%0d b=%0d less", i[7:4], i[3:0]),
                {7'd0, if4.less}, {7'd0, i[7:4] < i[3:0]});
        end
        for (int i = 0; i < 65536; i++) begin
            if8.a = i[15:8]; if8.b = i[7:0];
            #1;
            n_vec++;
            if (if8.greater !== (i[15:8] > i[7:0]) || if8.less !== (i[15:8] < i[7:0])) begin
                n_err++;
                $display("FAIL w8 a=%0h b=%0h: got gt=%b lt=%b expected gt=%b lt=%b",
                         i[15:8], i[7:0], if8.greater, if8.less,
                         i[15:8] > i[7:0], i[15:8] < i[7:0]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
